// File: rtl/pulse_sequencer.sv
// pulse_sequencer: shot controller for the single-pulse generator.
// Takes a start/trigger edge, latches the pulse config and runs a burst of strobe/launch_DL handshakes.
module pulse_sequencer #(
  parameter int unsigned     SETUP_CYC = 2,
  parameter int unsigned     TO_W      = 32,
  parameter logic [TO_W-1:0] TIMEOUT   = {TO_W{1'b1}}
) (
  input  logic        clk_Seq,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        ext_trig,
  input  logic [3:0]  src_sel,
  input  logic [4:0]  mlt_cfg,
  input  logic [16:0] dur_cfg,
  input  logic [7:0]  burst_len,
  input  logic [15:0] gap_len,
  input  logic        abort,
  input  logic        launch_DL,
  output logic        PL_start,
  output logic        PL_launch,
  output logic [3:0]  CHTS,
  output logic [4:0]  pl_mlt,
  output logic [16:0] duration,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [7:0]  shot_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_REL, S_GAP, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            btn_p0, ext_p0, trig;
  logic [15:0]     cnt, cnt_nxt;
  logic [TO_W-1:0] wd, wd_nxt, wd_inc;
  logic            wd_exp, last_shot, accept;
  logic            abort_q, abort_nxt;
  logic [7:0]      burst_q, shot_nxt;
  logic [15:0]     gap_q;
  logic            tmo_nxt, start_nxt, launch_nxt;

  assign trig = ((src_sel == 4'd1) && btn_start && !btn_p0) ||
                ((src_sel == 4'd2) && ext_trig  && !ext_p0);

  // Watchdog saturates at all-ones so a disabled or huge TIMEOUT never wraps back to zero.
  assign wd_inc    = (wd == {TO_W{1'b1}}) ? wd : wd + 1'b1;
  assign wd_exp    = (TIMEOUT != '0) && (wd_inc >= TIMEOUT);
  assign last_shot = (shot_idx == burst_q - 8'd1);

  always_ff @(posedge clk_Seq or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trig && !abort) state_nxt = S_ARM;
      S_ARM:   if (abort) state_nxt = S_REL;
               else if (cnt == 16'(SETUP_CYC - 1)) state_nxt = S_FIRE;
      S_FIRE:  if (abort || launch_DL || wd_exp) state_nxt = S_REL;
      S_REL:   if (!launch_DL) begin
                 if (abort_q || abort)  state_nxt = S_IDLE;
                 else if (last_shot)    state_nxt = S_DONE;
                 else if (gap_q == '0)  state_nxt = S_ARM;
                 else                   state_nxt = S_GAP;
               end
      S_GAP:   if (abort) state_nxt = S_REL;
               else if (cnt == gap_q - 16'd1) state_nxt = S_ARM;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == S_IDLE) && (state_nxt == S_ARM);
    cnt_nxt    = cnt;
    wd_nxt     = wd;
    abort_nxt  = abort_q;
    shot_nxt   = shot_idx;
    tmo_nxt    = timeout_err;
    if (state_nxt != state)                          cnt_nxt = '0;
    else if ((state == S_ARM) || (state == S_GAP))   cnt_nxt = cnt + 16'd1;
    if ((state_nxt == S_FIRE) && (state != S_FIRE))  wd_nxt = '0;
    else if (state == S_FIRE)                        wd_nxt = wd_inc;
    if (accept) begin
      abort_nxt = 1'b0;
      shot_nxt  = '0;
      tmo_nxt   = 1'b0;
    end else if ((state != S_IDLE) && (state != S_DONE) && abort) begin
      abort_nxt = 1'b1;
    end else if ((state == S_FIRE) && !launch_DL && wd_exp) begin
      abort_nxt = 1'b1;
      tmo_nxt   = 1'b1;
    end
    if ((state == S_REL) && ((state_nxt == S_GAP) || (state_nxt == S_ARM)))
      shot_nxt = shot_idx + 8'd1;
    start_nxt  = (state_nxt == S_FIRE) && (CHTS == 4'd1);
    launch_nxt = (state_nxt == S_FIRE) && (CHTS != 4'd1);
  end

  always_ff @(posedge clk_Seq or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0      <= 1'b0;
      ext_p0      <= 1'b0;
      cnt         <= '0;
      wd          <= '0;
      abort_q     <= 1'b0;
      burst_q     <= '0;
      gap_q       <= '0;
      shot_idx    <= '0;
      timeout_err <= 1'b0;
      PL_start    <= 1'b0;
      PL_launch   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      CHTS        <= '0;
      pl_mlt      <= '0;
      duration    <= '0;
    end else begin
      btn_p0      <= btn_start;
      ext_p0      <= ext_trig;
      cnt         <= cnt_nxt;
      wd          <= wd_nxt;
      abort_q     <= abort_nxt;
      shot_idx    <= shot_nxt;
      timeout_err <= tmo_nxt;
      PL_start    <= start_nxt;
      PL_launch   <= launch_nxt;
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
      if (accept) begin
        CHTS     <= src_sel;
        pl_mlt   <= mlt_cfg;
        duration <= dur_cfg;
        burst_q  <= (burst_len == '0) ? 8'd1 : burst_len;
        gap_q    <= gap_len;
      end
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: scoreboard bench with a behavioural generator answering strobes via launch_DL.
module tb_pulse_sequencer;

  localparam int SETUP = 2;

  logic        clk_Seq = 1'b0;
  logic        rst_n, btn_start, ext_trig, abort, launch_DL;
  logic [3:0]  src_sel;
  logic [4:0]  mlt_cfg;
  logic [16:0] dur_cfg;
  logic [7:0]  burst_len;
  logic [15:0] gap_len;
  logic        PL_start, PL_launch, busy, done, timeout_err;
  logic [3:0]  CHTS;
  logic [4:0]  pl_mlt;
  logic [16:0] duration;
  logic [7:0]  shot_idx;

  typedef struct {
    logic [1:0]  chan;
    logic [7:0]  idx;
    logic [16:0] dur;
    logic [4:0]  mlt;
    logic [3:0]  chts;
    int          width;
    int          rise;
    int          gap;
  } shot_t;

  shot_t sb[$];
  int    cyc = 0, n_tests = 0, n_fail = 0, done_cnt = 0, fall_cnt = 0;
  logic  gen_en;

  pulse_sequencer #(.SETUP_CYC(SETUP), .TO_W(32), .TIMEOUT(32'd20)) dut (
    .clk_Seq(clk_Seq), .rst_n(rst_n), .btn_start(btn_start), .ext_trig(ext_trig),
    .src_sel(src_sel), .mlt_cfg(mlt_cfg), .dur_cfg(dur_cfg), .burst_len(burst_len),
    .gap_len(gap_len), .abort(abort), .launch_DL(launch_DL), .PL_start(PL_start),
    .PL_launch(PL_launch), .CHTS(CHTS), .pl_mlt(pl_mlt), .duration(duration),
    .busy(busy), .done(done), .timeout_err(timeout_err), .shot_idx(shot_idx)
  );

  always #5 clk_Seq = ~clk_Seq;
  always @(posedge clk_Seq) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk_val({pfx, "_PL_start"},    PL_start,    0);
    chk_val({pfx, "_PL_launch"},   PL_launch,   0);
    chk_val({pfx, "_CHTS"},        CHTS,        0);
    chk_val({pfx, "_pl_mlt"},      pl_mlt,      0);
    chk_val({pfx, "_duration"},    duration,    0);
    chk_val({pfx, "_busy"},        busy,        0);
    chk_val({pfx, "_done"},        done,        0);
    chk_val({pfx, "_timeout_err"}, timeout_err, 0);
    chk_val({pfx, "_shot_idx"},    shot_idx,    0);
  endtask

  // Generator: raises launch_DL after the strobe has been high 5 cycles, clears it 1 cycle after it falls.
  initial begin : gen_model
    int hi_cnt, lo_cnt;
    launch_DL = 1'b0;
    hi_cnt = 0;
    lo_cnt = 0;
    forever begin
      @(negedge clk_Seq);
      if (PL_start || PL_launch) begin
        hi_cnt++;
        lo_cnt = 0;
        if (gen_en && hi_cnt == 6) launch_DL = 1'b1;
      end else begin
        hi_cnt = 0;
        lo_cnt++;
        if (lo_cnt >= 2) launch_DL = 1'b0;
      end
    end
  end

  initial begin : monitor
    shot_t cur;
    logic  strb, strb_prev, done_prev;
    int    rise_cyc, last_fall;
    strb_prev = 1'b0;
    done_prev = 1'b0;
    rise_cyc  = 0;
    last_fall = 0;
    cur.width = -1;
    cur.gap   = -1;
    forever begin
      @(negedge clk_Seq);
      strb = PL_start | PL_launch;
      if (strb && !strb_prev) begin
        rise_cyc = cyc;
        if (sb.size() == 0) begin
          chk_val("sb_unexpected_strobe", 1, 0);
          cur.width = -1;
        end else begin
          cur = sb.pop_front();
          chk_val("strobe_chan", {PL_launch, PL_start}, cur.chan);
          chk_val("shot_idx", shot_idx, cur.idx);
          chk_val("duration", duration, cur.dur);
          chk_val("pl_mlt", pl_mlt, cur.mlt);
          chk_val("CHTS", CHTS, cur.chts);
          if (cur.rise >= 0) chk_val("trig_latency", cyc, cur.rise);
          if (cur.gap >= 0)  chk_val("gap_min", (cyc - last_fall) >= cur.gap, 1);
        end
      end
      if (!strb && strb_prev) begin
        if (cur.width >= 0) chk_val("strobe_width", cyc - rise_cyc, cur.width);
        last_fall = cyc;
        fall_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk_val("done_width", done_prev, 0);
      end
      strb_prev = strb;
      done_prev = done;
    end
  end

  task automatic run_burst(input logic [3:0] src, input logic [4:0] mlt, input logic [16:0] dur,
                           input logic [7:0] blen, input logic [15:0] glen, input int nexp,
                           input int width);
    shot_t s;
    @(negedge clk_Seq);
    src_sel = src; mlt_cfg = mlt; dur_cfg = dur; burst_len = blen; gap_len = glen;
    for (int i = 0; i < nexp; i++) begin
      s.chan  = (src == 4'd1) ? 2'b01 : 2'b10;
      s.idx   = 8'(i);
      s.dur   = dur;
      s.mlt   = mlt;
      s.chts  = src;
      s.width = width;
      s.rise  = (i == 0) ? cyc + 1 + SETUP : -1;
      s.gap   = (i == 0) ? -1 : int'(glen) + SETUP;
      sb.push_back(s);
    end
    if (src == 4'd1) btn_start = 1'b1;
    else             ext_trig  = 1'b1;
    @(negedge clk_Seq);
    btn_start = 1'b0; ext_trig = 1'b0;
    // Scramble live config: the burst must keep using the latched copy.
    dur_cfg = ~dur; mlt_cfg = ~mlt; burst_len = 8'd0; gap_len = 16'd0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk_Seq);
      n++;
    end
    chk_val({tag, "_idle"}, busy, 0);
  endtask

  initial begin : main
    int  base, n;
    logic busy_any;
    rst_n = 1'b0; btn_start = 1'b0; ext_trig = 1'b0; abort = 1'b0; gen_en = 1'b1;
    src_sel = '0; mlt_cfg = '0; dur_cfg = '0; burst_len = '0; gap_len = '0;
    repeat (3) @(negedge clk_Seq);
    chk_zero("rst");
    rst_n = 1'b1;

    base = done_cnt;
    run_burst(4'd1, 5'd1, 17'h1ABCD, 8'd1, 16'd0, 1, 6);
    chk_val("a_busy", busy, 1);
    wait_idle("a");
    chk_val("a_done", done_cnt - base, 1);
    chk_val("a_tmo", timeout_err, 0);
    chk_val("a_dur_hold", duration, 17'h1ABCD);

    base = done_cnt;
    run_burst(4'd2, 5'd2, 17'h0F0F0, 8'd3, 16'd4, 3, 6);
    wait_idle("b");
    chk_val("b_done", done_cnt - base, 1);
    chk_val("b_last_idx", shot_idx, 2);
    chk_val("b_dur_hold", duration, 17'h0F0F0);

    base = done_cnt;
    run_burst(4'd1, 5'h1F, 17'h00001, 8'd0, 16'd2, 1, 6);
    wait_idle("c");
    chk_val("c_done", done_cnt - base, 1);

    @(negedge clk_Seq);
    src_sel = 4'd3;
    busy_any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn_start = i[1]; ext_trig = i[1];
      @(negedge clk_Seq);
      busy_any |= busy;
    end
    btn_start = 1'b0; ext_trig = 1'b0;
    chk_val("sel3_busy", busy_any, 0);

    gen_en = 1'b0;
    base = done_cnt;
    run_burst(4'd2, 5'd1, 17'h12345, 8'd1, 16'd0, 1, 20);
    wait_idle("e");
    chk_val("e_tmo_set", timeout_err, 1);
    chk_val("e_no_done", done_cnt - base, 0);
    gen_en = 1'b1;
    run_burst(4'd2, 5'd1, 17'h22222, 8'd1, 16'd0, 1, 6);
    chk_val("e_tmo_clear", timeout_err, 0);
    wait_idle("e2");
    chk_val("e2_done", done_cnt - base, 1);

    base = done_cnt;
    n = fall_cnt;
    run_burst(4'd1, 5'd2, 17'h0AAAA, 8'd3, 16'd10, 2, 6);
    for (int i = 0; i < 200 && fall_cnt < n + 2; i++) @(negedge clk_Seq);
    chk_val("f_two_shots", fall_cnt - n, 2);
    repeat (3) @(negedge clk_Seq);
    abort = 1'b1;
    repeat (2) @(negedge clk_Seq);
    abort = 1'b0;
    wait_idle("f");
    repeat (20) @(negedge clk_Seq);
    chk_val("f_no_done", done_cnt - base, 0);
    chk_val("f_no_more", fall_cnt - n, 2);

    @(negedge clk_Seq);
    src_sel = 4'd1; abort = 1'b1;
    busy_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      btn_start = i[1];
      @(negedge clk_Seq);
      busy_any |= busy;
    end
    btn_start = 1'b0; abort = 1'b0;
    chk_val("g_abort_idle", busy_any, 0);

    gen_en = 1'b0;
    run_burst(4'd2, 5'd3, 17'h13579, 8'd1, 16'd0, 1, -1);
    for (int i = 0; i < 20 && !PL_launch; i++) @(negedge clk_Seq);
    chk_val("h_fire", PL_launch, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("h_async");
    @(negedge clk_Seq);
    rst_n = 1'b1;
    gen_en = 1'b1;

    repeat (5) @(negedge clk_Seq);
    chk_val("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : global_limit
    #400000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
